four_digit_decimal_timer: RTL

FOUR_DIGIT_DECIMAL_TIMER -- requirements
Module: four_digit_decimal_timer

---
 rtl/four_digit_decimal_timer_pkg.sv | 22 ++
 rtl/four_digit_decimal_timer_decade_counter.sv | 27 ++
 rtl/four_digit_decimal_timer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/four_digit_decimal_timer_pkg.sv
// Shared definitions for the four-digit decimal timer: FSM encoding,
// BCD limits and display-format constants.
package four_digit_decimal_timer_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUN     = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         DP_DIGIT   = 2;
  localparam int         NUM_DIGITS = 4;

  // Builds a display digit {DP, BCD}; the decimal point lights only on the
  // digit that separates seconds from hundredths (SS.hh).
  function automatic logic [4:0] pack_digit(input logic [3:0] bcd, input int idx);
    logic dp;
    dp = (idx == DP_DIGIT);
    return {dp, bcd};
  endfunction

endpackage

// File: rtl/four_digit_decimal_timer_decade_counter.sv
// One BCD decade (0..9) with synchronous clear and increment-enable.
// CARRY is combinational so a tick ripples through all decades on one edge.
module decade_counter
  import four_digit_decimal_timer_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLR,
  input  logic       INC,
  output logic [3:0] Q,
  output logic       CARRY
);

  assign CARRY = INC & (Q == BCD_MAX);

  // Digit register: clear beats increment, 9 rolls over to 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Q <= 4'd0;
    end else if (CLR) begin
      Q <= 4'd0;
    end else if (INC) begin
      Q <= (Q == BCD_MAX) ? 4'd0 : Q + 4'd1;
    end
  end

endmodule

// File: rtl/four_digit_decimal_timer.sv
// Four-digit BCD stopwatch (SS.hh) with run/pause/clear control, a
// prescaler dividing CLK down to the count rate, and a rollover/saturation
// pulse. WRAP_EN selects wrapping at 9999 or saturating and stopping there.
module four_digit_decimal_timer
  import four_digit_decimal_timer_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int WRAP_EN  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLEAR,
  output logic [4:0] DIGIT0,
  output logic [4:0] DIGIT1,
  output logic [4:0] DIGIT2,
  output logic [4:0] DIGIT3,
  output logic       RUNNING,
  output logic       WRAP
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam bit            SAT_MODE   = (WRAP_EN == 0);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic          all_nines;
  logic          saturated;
  logic          sat_event;
  logic          rollover;
  logic          wrap_nxt;

  logic          inc0, inc1, inc2, inc3;
  logic          carry0, carry1, carry2;
  logic [3:0]    q0, q1, q2, q3;

  assign tick      = (state == RUN) && (presc == PRESC_LAST);
  assign all_nines = (q0 == BCD_MAX) && (q1 == BCD_MAX) &&
                     (q2 == BCD_MAX) && (q3 == BCD_MAX);
  // Saturation only exists in non-wrapping mode; it blocks both counting and
  // restarting until the count is cleared.
  assign saturated = SAT_MODE && all_nines;
  assign sat_event = tick && saturated;

  // Gate the tick at saturation so 9999 holds instead of rolling over.
  assign inc0 = tick & ~saturated;
  assign inc1 = carry0;
  assign inc2 = carry1;
  assign inc3 = carry2;

  decade_counter u_digit0 (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (CLEAR),
    .INC   (inc0),
    .Q     (q0),
    .CARRY (carry0)
  );

  decade_counter u_digit1 (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (CLEAR),
    .INC   (inc1),
    .Q     (q1),
    .CARRY (carry1)
  );

  decade_counter u_digit2 (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (CLEAR),
    .INC   (inc2),
    .Q     (q2),
    .CARRY (carry2)
  );

  decade_counter u_digit3 (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (CLEAR),
    .INC   (inc3),
    .Q     (q3),
    .CARRY (rollover)
  );

  // Prescaler: advances only while running, holds the partial tick on pause.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc <= '0;
    end else if (CLEAR) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + PRESC_ONE;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= STOPPED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: CLEAR > STOP > START; saturation forces a stop.
  always_comb begin
    state_nxt = state;
    case (state)
      STOPPED: begin
        if (START && !STOP && !CLEAR && !saturated) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (CLEAR || STOP || sat_event) begin
          state_nxt = STOPPED;
        end
      end
      default: state_nxt = STOPPED;
    endcase
  end

  // A clear on the same edge as the top-of-range tick suppresses the pulse.
  assign wrap_nxt = (rollover | sat_event) & ~CLEAR;

  // One-cycle WRAP pulse register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WRAP <= 1'b0;
    end else begin
      WRAP <= wrap_nxt;
    end
  end

  assign RUNNING = (state == RUN);

  assign DIGIT0 = pack_digit(q0, 0);
  assign DIGIT1 = pack_digit(q1, 1);
  assign DIGIT2 = pack_digit(q2, 2);
  assign DIGIT3 = pack_digit(q3, 3);

endmodule
